param_inc_counter: RTL and testbench

- Parametrised, registered successor to the team's 16-bit half-adder incrementer.
- Holds a WIDTH-bit count and steps it up or down by one per enabled cycle.
- Supports synchronous clear, parallel load, and wrap or saturate mode, with a registered carry/borrow pulse.
- Used as the general-purpose counter for timers, address generators and loop counters in the lab datapaths.

---
 rtl/param_inc_counter.sv | 114 +++++++++++
 tb/tb_param_inc_counter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/param_inc_counter.sv
// Parametrised up/down counter with clear, load, wrap/saturate and a registered carry/borrow pulse; count and co update one edge after inputs are sampled.
// No backpressure: steps every enabled cycle. Optional compare-match output enabled by COUNTER_CMP_EN.
module param_inc_counter #(
  parameter int          WIDTH   = 16,
  parameter logic [31:0] RST_VAL = 32'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic             sat_mode,
`ifdef COUNTER_CMP_EN
  input  logic [WIDTH-1:0] cmp_val,
  output logic             cmp_match,
`endif
  output logic [WIDTH-1:0] count,
  output logic             co,
  output logic             at_max,
  output logic             at_min,
  output logic             sat_hit
);

  localparam logic [WIDTH-1:0] RST_CNT = RST_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] dec_val;
  logic [WIDTH:0]   carry;
  logic [WIDTH:0]   borrow;

  logic [WIDTH-1:0] count_nxt;
  logic             co_nxt;
  logic             sat_nxt;

  // Ripple chains: the final carry out is set only when count is all-ones,
  // the final borrow out only when count is zero.
  always_comb begin
    inc_val   = '0;
    dec_val   = '0;
    carry     = '0;
    borrow    = '0;
    carry[0]  = 1'b1;
    borrow[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      inc_val[i]  = count[i] ^ carry[i];
      carry[i+1]  = count[i] & carry[i];
      dec_val[i]  = count[i] ^ borrow[i];
      borrow[i+1] = ~count[i] & borrow[i];
    end
  end

  assign at_max = carry[WIDTH];
  assign at_min = borrow[WIDTH];

  always_comb begin
    count_nxt = count;
    co_nxt    = 1'b0;
    sat_nxt   = sat_hit;
    if (clr) begin
      count_nxt = RST_CNT;
      sat_nxt   = 1'b0;
    end else if (load) begin
      count_nxt = load_val;
    end else if (en) begin
      if (up) begin
        if (!at_max) begin
          count_nxt = inc_val;
        end else if (!sat_mode) begin
          count_nxt = inc_val;
          co_nxt    = 1'b1;
        end else begin
          sat_nxt   = 1'b1;
        end
      end else begin
        if (!at_min) begin
          count_nxt = dec_val;
        end else if (!sat_mode) begin
          count_nxt = dec_val;
          co_nxt    = 1'b1;
        end else begin
          sat_nxt   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= RST_CNT;
      co      <= 1'b0;
      sat_hit <= 1'b0;
    end else begin
      count   <= count_nxt;
      co      <= co_nxt;
      sat_hit <= sat_nxt;
    end
  end

`ifdef COUNTER_CMP_EN
  // Compared against the next count so the flag lines up with the registered count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_match <= 1'b0;
    end else if (clr) begin
      cmp_match <= 1'b0;
    end else begin
      cmp_match <= (count_nxt == cmp_val);
    end
  end
`endif

endmodule

// File: tb/tb_param_inc_counter.sv
// Scoreboard bench for param_inc_counter: directed scenarios then randomized traffic against an arithmetic model.
module tb_param_inc_counter;

  localparam int          W   = 16;
  localparam logic [31:0] RV  = 32'h0;
  localparam int unsigned MAX = (1 << W) - 1;

  typedef struct packed {
    logic [W-1:0] count;
    logic         co;
    logic         sat;
    logic         amax;
    logic         amin;
    logic         cmp;
  } exp_t;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         clr      = 1'b0;
  logic         load     = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         en       = 1'b0;
  logic         up       = 1'b0;
  logic         sat_mode = 1'b0;
  logic [W-1:0] cmp_val  = '0;
  logic [W-1:0] count;
  logic         co;
  logic         at_max;
  logic         at_min;
  logic         sat_hit;
`ifdef COUNTER_CMP_EN
  logic         cmp_match;
`endif

  int          tests = 0;
  int          fails = 0;
  exp_t        q[$];
  int unsigned m_count = 0;
  logic        m_sat   = 1'b0;

  param_inc_counter #(.WIDTH(W), .RST_VAL(RV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .up       (up),
    .sat_mode (sat_mode),
`ifdef COUNTER_CMP_EN
    .cmp_val  (cmp_val),
    .cmp_match(cmp_match),
`endif
    .count    (count),
    .co       (co),
    .at_max   (at_max),
    .at_min   (at_min),
    .sat_hit  (sat_hit)
  );

  always #5 clk = ~clk;

  function automatic exp_t dut_view();
    exp_t a;
    a.count = count;
    a.co    = co;
    a.sat   = sat_hit;
    a.amax  = at_max;
    a.amin  = at_min;
    a.cmp   = 1'b0;
`ifdef COUNTER_CMP_EN
    a.cmp   = cmp_match;
`endif
    return a;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got count=%h co=%b sat_hit=%b at_max=%b at_min=%b cmp=%b, expected count=%h co=%b sat_hit=%b at_max=%b at_min=%b cmp=%b",
               name, $time, act.count, act.co, act.sat, act.amax, act.amin, act.cmp,
               exp.count, exp.co, exp.sat, exp.amax, exp.amin, exp.cmp);
    end
  endtask

  // Reference: counts are plain integers modulo 2^W, wrap/saturate decided by comparison with the bounds.
  task automatic apply(input logic r, input logic c, input logic l, input logic [W-1:0] lv,
                       input logic e, input logic u, input logic s);
    exp_t x;
    rst_n = r; clr = c; load = l; load_val = lv; en = e; up = u; sat_mode = s;
    x.co  = 1'b0;
    x.cmp = 1'b0;
    if (!r || c) begin
      m_count = RV & MAX;
      m_sat   = 1'b0;
    end else if (l) begin
      m_count = int'(lv);
    end else if (e) begin
      if (u) begin
        if (m_count == MAX) begin
          if (s) m_sat = 1'b1;
          else begin m_count = 0; x.co = 1'b1; end
        end else m_count = m_count + 1;
      end else begin
        if (m_count == 0) begin
          if (s) m_sat = 1'b1;
          else begin m_count = MAX; x.co = 1'b1; end
        end else m_count = m_count - 1;
      end
    end
    x.count = m_count[W-1:0];
    x.sat   = m_sat;
    x.amax  = (m_count == MAX);
    x.amin  = (m_count == 0);
`ifdef COUNTER_CMP_EN
    x.cmp   = r && !c && (m_count == int'(cmp_val));
`endif
    q.push_back(x);
  endtask

  task automatic drive(input logic r, input logic c, input logic l, input logic [W-1:0] lv,
                       input logic e, input logic u, input logic s);
    @(negedge clk);
    apply(r, c, l, lv, e, u, s);
  endtask

  // Drops reset between edges and checks the outputs before any clock edge can act.
  task automatic async_reset();
    exp_t x;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    x.count = RV[W-1:0];
    x.co    = 1'b0;
    x.sat   = 1'b0;
    x.amax  = (RV[W-1:0] == MAX[W-1:0]);
    x.amin  = (RV[W-1:0] == '0);
    x.cmp   = 1'b0;
    check("async_reset", dut_view(), x);
    apply(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("cycle", dut_view(), e);
      end
    end
  end

  initial begin : stimulus
    logic [W-1:0] lv;
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of counting
    drive(1'b1, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    async_reset();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Up wrap
    drive(1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Down saturate
    drive(1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Priority: clr over load over en, then load alone
    drive(1'b1, 1'b1, 1'b1, 16'hAAAA, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);

    // Hold and direction change
    drive(1'b1, 1'b0, 1'b1, 16'h0010, 1'b0, 1'b0, 1'b0);
    repeat (2) drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Compare match while counting up through 5
    cmp_val = 16'h0005;
    drive(1'b1, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Randomized traffic, loads biased toward the bounds to exercise wrap and saturation
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 4))
        0:       lv = '0;
        1:       lv = 16'h0001;
        2:       lv = MAX[W-1:0] - 16'h1;
        3:       lv = MAX[W-1:0];
        default: lv = W'($urandom);
      endcase
      cmp_val = ($urandom_range(0, 1) == 1) ? W'(m_count + 1) : W'($urandom);
      drive(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 9) == 0),
            lv,
            ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end

    drive(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
